// File: rtl/rect_cmd_sequencer.sv
// Buffers rectangle draw commands in a small FIFO and issues them one at a time
// to the rectangle renderer, holding enable for the whole draw.
module rect_cmd_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned X_W   = 9,
  parameter int unsigned Y_W   = 8,
  parameter int unsigned C_W   = 3
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [X_W-1:0]                   cmd_origin_x,
  input  logic [Y_W-1:0]                   cmd_origin_y,
  input  logic [X_W-1:0]                   cmd_width,
  input  logic [Y_W-1:0]                   cmd_height,
  input  logic [C_W-1:0]                   cmd_back_color,
  input  logic                             cmd_border,
  input  logic [C_W-1:0]                   cmd_border_color,
  input  logic                             flush,
  output logic                             r_enable,
  output logic [X_W-1:0]                   r_origin_x,
  output logic [Y_W-1:0]                   r_origin_y,
  output logic [X_W-1:0]                   r_width,
  output logic [Y_W-1:0]                   r_height,
  output logic [C_W-1:0]                   r_back_color,
  output logic                             r_border,
  output logic [C_W-1:0]                   r_border_color,
  input  logic                             r_done,
  output logic [$clog2(DEPTH):0]           queue_count,
  output logic                             busy,
  output logic                             cmd_dropped
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [X_W-1:0] origin_x;
    logic [Y_W-1:0] origin_y;
    logic [X_W-1:0] width;
    logic [Y_W-1:0] height;
    logic [C_W-1:0] back_color;
    logic           border;
    logic [C_W-1:0] border_color;
  } rect_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ARM     = 3'd2,
    DRAW    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  rect_t             mem [DEPTH];
  rect_t             cmd_in;
  rect_t             head;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  state_t            state;
  state_t            state_nxt;
  logic              push_fire;
  logic              push_zero;
  logic              push_store;
  logic              pop;
  logic              enable_nxt;

  assign cmd_in = '{origin_x:     cmd_origin_x,
                    origin_y:     cmd_origin_y,
                    width:        cmd_width,
                    height:       cmd_height,
                    back_color:   cmd_back_color,
                    border:       cmd_border,
                    border_color: cmd_border_color};

  assign cmd_ready   = (count < CNT_W'(DEPTH));
  assign push_fire   = cmd_valid && cmd_ready;
  assign push_zero   = (cmd_width == '0) || (cmd_height == '0);
  // Zero-size commands are consumed but never stored; flush wins over a push.
  assign push_store  = push_fire && !push_zero && !flush;
  assign pop         = (state == LOAD);
  assign head        = mem[rd_ptr];
  assign queue_count = count;
  assign busy        = (state != IDLE) || (count != '0);

  // Storage array needs no reset: contents are only read behind a nonzero count.
  always_ff @(posedge clock) begin
    if (push_store) begin
      mem[wr_ptr] <= cmd_in;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_store);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      count  <= count + CNT_W'(push_store) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ARM ignores r_done so a done left over from the previous draw is never taken.
  always_comb begin
    state_nxt  = state;
    enable_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if ((count != '0) && !flush) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = ARM;
      end
      ARM: begin
        enable_nxt = 1'b1;
        state_nxt  = DRAW;
      end
      DRAW: begin
        enable_nxt = 1'b1;
        if (r_done) state_nxt = RELEASE;
      end
      RELEASE: begin
        if ((count != '0) && !flush) state_nxt = LOAD;
        else                         state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Renderer-facing registers; attributes change only when leaving LOAD.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_enable       <= 1'b0;
      r_origin_x     <= '0;
      r_origin_y     <= '0;
      r_width        <= '0;
      r_height       <= '0;
      r_back_color   <= '0;
      r_border       <= 1'b0;
      r_border_color <= '0;
      cmd_dropped    <= 1'b0;
    end else begin
      r_enable    <= enable_nxt;
      cmd_dropped <= push_fire && push_zero;
      if (pop) begin
        r_origin_x     <= head.origin_x;
        r_origin_y     <= head.origin_y;
        r_width        <= head.width;
        r_height       <= head.height;
        r_back_color   <= head.back_color;
        r_border       <= head.border;
        r_border_color <= head.border_color;
      end
    end
  end

endmodule

// File: tb/tb_rect_cmd_sequencer.sv
// Scoreboard bench for rect_cmd_sequencer: a timeline reference model predicts
// the issued rectangles and per-cycle status; a monitor compares after each edge.
module tb_rect_cmd_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned X_W   = 9;
  localparam int unsigned Y_W   = 8;
  localparam int unsigned C_W   = 3;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic [X_W-1:0] origin_x;
    logic [Y_W-1:0] origin_y;
    logic [X_W-1:0] width;
    logic [Y_W-1:0] height;
    logic [C_W-1:0] back_color;
    logic           border;
    logic [C_W-1:0] border_color;
  } rect_t;

  logic             clock;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [X_W-1:0]   cmd_origin_x;
  logic [Y_W-1:0]   cmd_origin_y;
  logic [X_W-1:0]   cmd_width;
  logic [Y_W-1:0]   cmd_height;
  logic [C_W-1:0]   cmd_back_color;
  logic             cmd_border;
  logic [C_W-1:0]   cmd_border_color;
  logic             flush;
  logic             r_enable;
  logic [X_W-1:0]   r_origin_x;
  logic [Y_W-1:0]   r_origin_y;
  logic [X_W-1:0]   r_width;
  logic [Y_W-1:0]   r_height;
  logic [C_W-1:0]   r_back_color;
  logic             r_border;
  logic [C_W-1:0]   r_border_color;
  logic             r_done;
  logic [CNT_W-1:0] queue_count;
  logic             busy;
  logic             cmd_dropped;

  rect_cmd_sequencer #(.DEPTH(DEPTH), .X_W(X_W), .Y_W(Y_W), .C_W(C_W)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_origin_x(cmd_origin_x), .cmd_origin_y(cmd_origin_y),
    .cmd_width(cmd_width), .cmd_height(cmd_height),
    .cmd_back_color(cmd_back_color), .cmd_border(cmd_border),
    .cmd_border_color(cmd_border_color), .flush(flush),
    .r_enable(r_enable), .r_origin_x(r_origin_x), .r_origin_y(r_origin_y),
    .r_width(r_width), .r_height(r_height), .r_back_color(r_back_color),
    .r_border(r_border), .r_border_color(r_border_color), .r_done(r_done),
    .queue_count(queue_count), .busy(busy), .cmd_dropped(cmd_dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending queue plus edge-number timeline of the issuer.
  rect_t mq[$];
  rect_t sb_q[$];
  int    cyc;
  int    pop_edge, watch_from, free_from, en_on, en_off;
  bit    free_b;
  logic  exp_en, exp_drop, exp_idle;
  int    exp_count;
  rect_t exp_attr;
  bit    chk_en;
  logic  prev_en;

  task automatic model_reset();
    mq.delete();
    sb_q.delete();
    cyc = 0; pop_edge = -1; watch_from = -1; free_from = 0;
    en_on = -1; en_off = -1; free_b = 1'b1;
    exp_en = 1'b0; exp_drop = 1'b0; exp_idle = 1'b1; exp_count = 0; exp_attr = '0;
  endtask

  function automatic rect_t rnd_rect(input bit allow_zero);
    rect_t r;
    r.origin_x     = X_W'($urandom_range(0, 319));
    r.origin_y     = Y_W'($urandom_range(0, 239));
    r.width        = X_W'($urandom_range(1, 320));
    r.height       = Y_W'($urandom_range(1, 240));
    r.back_color   = C_W'($urandom);
    r.border       = 1'($urandom);
    r.border_color = C_W'($urandom);
    if (allow_zero && ($urandom_range(0, 7) == 0)) begin
      if ($urandom_range(0, 1) == 0) r.width = '0;
      else                           r.height = '0;
    end
    return r;
  endfunction

  // Drive one cycle's inputs, advance the model to the coming edge, wait a cycle.
  task automatic step(input bit v, input rect_t c, input bit f, input bit d);
    int n;
    int cnt_pre;
    bit fire;
    bit zero;
    n = cyc;
    cmd_valid = v; flush = f; r_done = d;
    cmd_origin_x = c.origin_x; cmd_origin_y = c.origin_y;
    cmd_width = c.width; cmd_height = c.height;
    cmd_back_color = c.back_color; cmd_border = c.border;
    cmd_border_color = c.border_color;
    cnt_pre = mq.size();
    fire = v && (cnt_pre < DEPTH);
    zero = fire && ((c.width == '0) || (c.height == '0));
    if (pop_edge == n) begin
      exp_attr = mq.pop_front();
      sb_q.push_back(exp_attr);
      watch_from = n + 2;
      en_on = n + 1;
      pop_edge = -1;
    end else if (watch_from >= 0 && n >= watch_from && d) begin
      watch_from = -1;
      free_b = 1'b1;
      free_from = n + 1;
      en_off = n + 1;
      exp_idle = 1'b0;
    end else if (free_b && n >= free_from) begin
      if (cnt_pre > 0 && !f) begin
        free_b = 1'b0;
        pop_edge = n + 1;
        exp_idle = 1'b0;
      end else begin
        exp_idle = 1'b1;
      end
    end
    if (f)                 mq.delete();
    else if (fire && !zero) mq.push_back(c);
    if (n == en_on)  exp_en = 1'b1;
    if (n == en_off) exp_en = 1'b0;
    exp_drop  = zero;
    exp_count = mq.size();
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  // Monitor: per-cycle status plus scoreboard pop on each new enable.
  always @(posedge clock) begin
    #1;
    if (chk_en) begin
      rect_t act;
      act = '{r_origin_x, r_origin_y, r_width, r_height, r_back_color, r_border, r_border_color};
      check("queue_count", 64'(queue_count), 64'(exp_count));
      check("cmd_ready", 64'(cmd_ready), 64'(exp_count < DEPTH));
      check("r_enable", 64'(r_enable), 64'(exp_en));
      check("cmd_dropped", 64'(cmd_dropped), 64'(exp_drop));
      check("busy", 64'(busy), 64'(!exp_idle || exp_count != 0));
      check("r_attr_hold", 64'(act), 64'(exp_attr));
      if (r_enable && !prev_en) begin
        if (sb_q.size() == 0) begin
          check("issue_unexpected", 64'(act), 64'(0));
        end else begin
          check("issue_order", 64'(act), 64'(sb_q.pop_front()));
        end
      end
      prev_en = r_enable;
    end else begin
      prev_en = 1'b0;
    end
  end

  initial begin
    rect_t z;
    rect_t one;
    z = '0;
    chk_en = 1'b0;
    reset = 1'b1;
    cmd_valid = 1'b0; flush = 1'b0; r_done = 1'b0;
    cmd_origin_x = '0; cmd_origin_y = '0; cmd_width = '0; cmd_height = '0;
    cmd_back_color = '0; cmd_border = 1'b0; cmd_border_color = '0;
    model_reset();
    #12;
    check("rst_r_enable", 64'(r_enable), 64'(0));
    check("rst_queue_count", 64'(queue_count), 64'(0));
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_cmd_dropped", 64'(cmd_dropped), 64'(0));
    check("rst_r_width", 64'(r_width), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    chk_en = 1'b1;

    // Single rectangle: latency and completion back to idle.
    one = '{9'd10, 8'd20, 9'd4, 8'd3, 3'b010, 1'b1, 3'b111};
    step(1'b1, one, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) step(1'b0, z, 1'b0, 1'b0);
    step(1'b0, z, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, z, 1'b0, 1'b0);

    // Fill past DEPTH with the renderer stalled, then drain with done held high.
    for (int i = 0; i < 9; i++) step(1'b1, rnd_rect(1'b0), 1'b0, 1'b0);
    one = rnd_rect(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, one, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) step(1'b0, z, 1'b0, 1'b1);

    // Zero-width command is consumed and dropped.
    one = '{9'd5, 8'd5, 9'd0, 8'd5, 3'b001, 1'b0, 3'b000};
    step(1'b1, one, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, z, 1'b0, 1'b0);

    // Flush during the first of four draws.
    for (int i = 0; i < 4; i++) step(1'b1, rnd_rect(1'b0), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, z, 1'b0, 1'b0);
    step(1'b0, z, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, z, 1'b0, 1'b0);
    step(1'b0, z, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, z, 1'b0, 1'b0);

    // Asynchronous reset while drawing with three commands queued.
    for (int i = 0; i < 4; i++) step(1'b1, rnd_rect(1'b0), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, z, 1'b0, 1'b0);
    check("pre_rst_enable", 64'(r_enable), 64'(1));
    check("pre_rst_count", 64'(queue_count), 64'(3));
    chk_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_enable", 64'(r_enable), 64'(0));
    check("async_rst_count", 64'(queue_count), 64'(0));
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, z, 1'b0, 1'($urandom_range(0, 1)));

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 1) == 1), rnd_rect(1'b1),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 60; i++) step(1'b0, z, 1'b0, 1'b1);
    check("final_sb_empty", 64'(sb_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
